// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA sprite overlay path.
// Counters span a 1024x512 coordinate space.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   localparam int X_W   = 10;
   localparam int Y_W   = 9;
   localparam int BGR_W = 24;

   typedef logic [BGR_W-1:0] bgr_t;

   localparam bgr_t BLANK_BGR = 24'h000000;

   localparam logic [X_W-1:0] X_MAX = '1;
   localparam logic [Y_W-1:0] Y_MAX = '1;

endpackage

// File: rtl/sprite_hit.sv
// Registered rectangle hit test for one sprite channel.
// Right/bottom edges are formed one bit wider so they never wrap.
module sprite_hit
   import vga_pkg::*;
#(
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32
) (
   input  logic           iVGA_CLK,
   input  logic           iRST_n,
   input  logic [X_W-1:0] x,
   input  logic [Y_W-1:0] y,
   input  logic [X_W-1:0] sx,
   input  logic [Y_W-1:0] sy,
   input  logic           en,
   output logic           hit
);

   logic [X_W:0] x_end;
   logic [Y_W:0] y_end;
   logic         in_x;
   logic         in_y;

   assign x_end = {1'b0, sx} + (X_W+1)'(SPRITE_W);
   assign y_end = {1'b0, sy} + (Y_W+1)'(SPRITE_H);

   assign in_x = (x >= sx) && ({1'b0, x} < x_end);
   assign in_y = (y >= sy) && ({1'b0, y} < y_end);

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) hit <= 1'b0;
      else         hit <= en && in_x && in_y;
   end

endmodule

// File: rtl/vga_sprite_compositor.sv
// Fixed-priority sprite overlay with 2-cycle aligned sync/blank.
// Define SPRITE_COLLISION_EN to build the per-frame overlap flags.
module vga_sprite_compositor
   import vga_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int SPRITE_W    = 32,
   parameter int SPRITE_H    = 32,
   parameter int H_ACTIVE    = H_ACTIVE_DEF,
   parameter int V_ACTIVE    = V_ACTIVE_DEF
) (
   input  logic                         iVGA_CLK,
   input  logic                         iRST_n,
   input  logic                         iBLANK_n,
   input  logic                         iHS,
   input  logic                         iVS,
   input  logic [BGR_W-1:0]             bg_bgr,
   input  logic [X_W*NUM_SPRITES-1:0]   sprite_x,
   input  logic [Y_W*NUM_SPRITES-1:0]   sprite_y,
   input  logic [NUM_SPRITES-1:0]       sprite_en,
   input  logic [BGR_W*NUM_SPRITES-1:0] sprite_bgr,
   output logic                         oBLANK_n,
   output logic                         oHS,
   output logic                         oVS,
   output logic [BGR_W-1:0]             o_bgr,
   output logic                         frame_start,
   output logic [NUM_SPRITES-1:0]       collision
);

   logic [X_W-1:0]               x_cnt;
   logic [Y_W-1:0]               y_cnt;
   logic                         fs;

   logic [X_W*NUM_SPRITES-1:0]   sh_x;
   logic [Y_W*NUM_SPRITES-1:0]   sh_y;
   logic [NUM_SPRITES-1:0]       sh_en;
   logic [BGR_W*NUM_SPRITES-1:0] sh_bgr;

   logic [NUM_SPRITES-1:0]       hit_vec;
   bgr_t                         bg_d1;
   logic                         blank_d1;
   logic                         hs_d1;
   logic                         vs_d1;
   logic                         in_area_d1;
   bgr_t                         mux_bgr;

   // vs_d1 doubles as the previous-cycle iVS for edge detection
   assign fs = vs_d1 && !iVS;

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         if (!iBLANK_n)
            x_cnt <= '0;
         else if (x_cnt != X_MAX)
            x_cnt <= x_cnt + X_W'(1);
         if (!iVS)
            y_cnt <= '0;
         else if (blank_d1 && !iBLANK_n && y_cnt != Y_MAX)
            y_cnt <= y_cnt + Y_W'(1);
      end
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         sh_x        <= '0;
         sh_y        <= '0;
         sh_en       <= '0;
         sh_bgr      <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= fs;
         if (fs) begin
            sh_x   <= sprite_x;
            sh_y   <= sprite_y;
            sh_en  <= sprite_en;
            sh_bgr <= sprite_bgr;
         end
      end
   end

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_hit
      sprite_hit #(
         .SPRITE_W (SPRITE_W),
         .SPRITE_H (SPRITE_H)
      ) u_hit (
         .iVGA_CLK (iVGA_CLK),
         .iRST_n   (iRST_n),
         .x        (x_cnt),
         .y        (y_cnt),
         .sx       (sh_x[i*X_W +: X_W]),
         .sy       (sh_y[i*Y_W +: Y_W]),
         .en       (sh_en[i]),
         .hit      (hit_vec[i])
      );
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         bg_d1      <= BLANK_BGR;
         blank_d1   <= 1'b0;
         hs_d1      <= 1'b1;
         vs_d1      <= 1'b1;
         in_area_d1 <= 1'b0;
      end else begin
         bg_d1      <= bg_bgr;
         blank_d1   <= iBLANK_n;
         hs_d1      <= iHS;
         vs_d1      <= iVS;
         in_area_d1 <= (x_cnt < X_W'(H_ACTIVE)) &&
                       (y_cnt < Y_W'(V_ACTIVE));
      end
   end

   // descending scan so the lowest index wins
   always_comb begin
      mux_bgr = bg_d1;
      for (int i = NUM_SPRITES-1; i >= 0; i--)
         if (hit_vec[i]) mux_bgr = sh_bgr[i*BGR_W +: BGR_W];
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         o_bgr    <= BLANK_BGR;
         oBLANK_n <= 1'b0;
         oHS      <= 1'b1;
         oVS      <= 1'b1;
      end else begin
         o_bgr    <= blank_d1 ? mux_bgr : BLANK_BGR;
         oBLANK_n <= blank_d1;
         oHS      <= hs_d1;
         oVS      <= vs_d1;
      end
   end

`ifdef SPRITE_COLLISION_EN
   logic [NUM_SPRITES-1:0] coll_acc;
   logic                   multi_hit;

   assign multi_hit =
      |(hit_vec & (hit_vec - NUM_SPRITES'(1)));

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         coll_acc  <= '0;
         collision <= '0;
      end else if (fs) begin
         collision <= coll_acc;
         coll_acc  <= '0;
      end else if (blank_d1 && in_area_d1 && multi_hit) begin
         coll_acc  <= coll_acc | hit_vec;
      end
   end
`else
   assign collision = '0;
`endif

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Scoreboard bench for vga_sprite_compositor using a compressed raster.
// Short lines everywhere except the rows each scenario inspects.
module tb_vga_sprite_compositor;

   localparam int N  = 4;
   localparam int SW = 32;
   localparam int SH = 32;

   typedef struct {
      logic [26:0] v;
      int          x;
      int          y;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            blank_n;
   logic            hs;
   logic            vs;
   logic [23:0]     bg;
   logic [10*N-1:0] sx;
   logic [9*N-1:0]  sy;
   logic [N-1:0]    sen;
   logic [24*N-1:0] scol;

   logic            o_blank_n;
   logic            o_hs;
   logic            o_vs;
   logic [23:0]     o_bgr;
   logic            fstart;
   logic [N-1:0]    coll;

   int           checks = 0;
   int           errors = 0;
   int           m_x [N];
   int           m_y [N];
   logic [N-1:0] m_en;
   logic [23:0]  m_col [N];
   logic [N-1:0] acc;
   logic [N-1:0] exp_coll;
   bit           vs_prev;
   bit           exp_fs;
   exp_t         q [$];

   always #5 clk = ~clk;

   vga_sprite_compositor #(
      .NUM_SPRITES (N),
      .SPRITE_W    (SW),
      .SPRITE_H    (SH),
      .H_ACTIVE    (640),
      .V_ACTIVE    (480)
   ) dut (
      .iVGA_CLK    (clk),
      .iRST_n      (rst_n),
      .iBLANK_n    (blank_n),
      .iHS         (hs),
      .iVS         (vs),
      .bg_bgr      (bg),
      .sprite_x    (sx),
      .sprite_y    (sy),
      .sprite_en   (sen),
      .sprite_bgr  (scol),
      .oBLANK_n    (o_blank_n),
      .oHS         (o_hs),
      .oVS         (o_vs),
      .o_bgr       (o_bgr),
      .frame_start (fstart),
      .collision   (coll)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want, input int x, input int y);
      checks++;
      assert (got === want) else begin
         errors++;
         $error("FAIL %s x=%0d y=%0d got=%h want=%h", tag, x, y, got, want);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_x[i]   = 0;
         m_y[i]   = 0;
         m_col[i] = 24'h0;
      end
      m_en     = '0;
      acc      = '0;
      exp_coll = '0;
      vs_prev  = 1'b1;
      q.delete();
   endtask

   task automatic reset_checks();
      chk("rst_bgr",   32'(o_bgr),     32'h0, -1, -1);
      chk("rst_blank", 32'(o_blank_n), 32'h0, -1, -1);
      chk("rst_hs",    32'(o_hs),      32'h1, -1, -1);
      chk("rst_vs",    32'(o_vs),      32'h1, -1, -1);
      chk("rst_fs",    32'(fstart),    32'h0, -1, -1);
      chk("rst_coll",  32'(coll),      32'h0, -1, -1);
   endtask

   function automatic logic [N-1:0] model_hits(input int x, input int y);
      logic [N-1:0] h;
      for (int i = 0; i < N; i++)
         h[i] = m_en[i] && x >= m_x[i] && x < m_x[i] + SW &&
                y >= m_y[i] && y < m_y[i] + SH;
      return h;
   endfunction

   task automatic step(input logic b, input logic h, input logic v,
                       input int x, input int y);
      logic [N-1:0] hv;
      logic [23:0]  pix;
      exp_t         e;
      @(negedge clk);
      blank_n = b;
      hs      = h;
      vs      = v;
      hv      = model_hits(x, y);
      pix     = 24'h0;
      if (b) begin
         pix = bg;
         for (int i = N-1; i >= 0; i--)
            if (hv[i]) pix = m_col[i];
      end
      e.v = {b, h, v, pix};
      e.x = x;
      e.y = y;
      q.push_back(e);
      exp_fs  = vs_prev && !v;
      vs_prev = v;
`ifdef SPRITE_COLLISION_EN
      if (b && $countones(hv) >= 2) acc |= hv;
`endif
      if (exp_fs) begin
`ifdef SPRITE_COLLISION_EN
         exp_coll = acc;
         acc      = '0;
`endif
         for (int i = 0; i < N; i++) begin
            m_x[i]   = int'(sx[i*10 +: 10]);
            m_y[i]   = int'(sy[i*9 +: 9]);
            m_col[i] = scol[i*24 +: 24];
         end
         m_en = sen;
      end
      @(posedge clk);
      #1;
      chk("frame_start", 32'(fstart), 32'(exp_fs), x, y);
      chk("collision", 32'(coll), 32'(exp_coll), x, y);
      if (q.size() >= 2) begin
         e = q.pop_front();
         chk("pixel", 32'({o_blank_n, o_hs, o_vs, o_bgr}),
             32'(e.v), e.x, e.y);
      end
   endtask

   task automatic run_line(input int l, input int aw,
                           input bit act, input bit vsl);
      for (int c = 0; c < aw + 8; c++)
         step(act && c < aw, !(c >= aw + 2 && c < aw + 6), !vsl, c, l);
   endtask

   task automatic run_vblank();
      for (int l = 0; l < 6; l++)
         run_line(480 + l, 8, 1'b0, l == 2 || l == 3);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      reset_checks();
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_frame(input int lo, input int hi, input int ww,
                            input int chg_line, input int rst_line);
      for (int l = 0; l < 480; l++) begin
         if (l == chg_line) begin
            sx[9:0] = 10'd630;
            sy[8:0] = 9'd470;
            sen[1]  = 1'b0;
         end
         if (l == rst_line) pulse_reset();
         run_line(l, (l >= lo && l <= hi) ? ww : 8, 1'b1, 1'b0);
      end
      run_vblank();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      blank_n = 1'b0;
      hs      = 1'b1;
      vs      = 1'b1;
      bg      = 24'h123456;
      sx      = '0;
      sy      = '0;
      sen     = '0;
      scol    = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset_checks();
      @(negedge clk);
      rst_n = 1'b1;

      run_vblank();

      // sprite 0 requested now, shown only after this frame's vsync
      sx[9:0]   = 10'd100;
      sy[8:0]   = 9'd50;
      scol[23:0] = 24'h0000FF;
      sen[0]    = 1'b1;
      run_frame(0, 1, 640, -1, -1);

      // overlap config for the next frame, staged mid-sequence
      sx[9:0]    = 10'd200;
      sy[8:0]    = 9'd200;
      sx[19:10]  = 10'd210;
      sy[17:9]   = 9'd210;
      scol[47:24] = 24'h00FF00;
      sen[1]     = 1'b1;
      run_frame(48, 83, 140, -1, -1);

      run_frame(198, 243, 250, 240, -1);

      bg = 24'hABCDEF;
      run_frame(468, 479, 640, -1, -1);

      run_frame(468, 479, 640, -1, 300);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
